// File: rtl/wreq_dw_align_pkg.sv
// Shared widths, header/tuser field offsets, FSM states and
// the byte-shift helper for the DMA write-request DW aligner.
package wreq_dw_align_pkg;

    localparam int DMA_DATA_W   = 256;
    localparam int DMA_HEAD_W   = 128;
    localparam int AXIS_TUSER_W = 128;
    localparam int DMA_KEEP_W   = DMA_DATA_W / 32;
    localparam int BLEN_W       = 13;
    localparam int DWLEN_W      = 11;
    localparam int BEAT_W       = 9;
    localparam int CARRY_W      = 24;

    localparam int HD_ADDR_LSB  = 32;
    localparam int HD_LEN_LSB   = 0;
    localparam int TU_ADDR_LSB  = 32;
    localparam int TU_DWLEN_LSB = 8;
    localparam int TU_FBE_LSB   = 4;
    localparam int TU_LBE_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_FLUSH,
        ST_DROP
    } state_t;

    // Shift beat up by off bytes, filling the bottom from the previous beat's top bytes.
    function automatic logic [DMA_DATA_W-1:0] dw_shift(
        input logic [DMA_DATA_W-1:0] cur,
        input logic [CARRY_W-1:0]    carry,
        input logic [1:0]            off
    );
        logic [DMA_DATA_W-1:0] res;
        unique case (off)
            2'd0: res = cur;
            2'd1: res = {cur[DMA_DATA_W-9:0],  carry[23:16]};
            2'd2: res = {cur[DMA_DATA_W-17:0], carry[23:8]};
            2'd3: res = {cur[DMA_DATA_W-25:0], carry[23:0]};
        endcase
        return res;
    endfunction

    function automatic logic [DMA_KEEP_W-1:0] last_keep(
        input logic [DWLEN_W-1:0] dw_len
    );
        logic [2:0] k;
        k = dw_len[2:0] - 3'd1;
        return 8'hFF >> (3'd7 - k);
    endfunction

endpackage

// File: rtl/wreq_dw_align_if.sv
// Handshake bundles: DMA write-request input and aligned AXI-stream output.
interface wreq_if;
    import wreq_dw_align_pkg::*;

    logic                  valid;
    logic                  last;
    logic [DMA_HEAD_W-1:0] head;
    logic [DMA_DATA_W-1:0] data;
    logic                  ready;

    modport master (output valid, last, head, data, input ready);
    modport slave  (input valid, last, head, data, output ready);
endinterface

interface axis_wr_if;
    import wreq_dw_align_pkg::*;

    logic                    tvalid;
    logic                    tlast;
    logic [DMA_DATA_W-1:0]   tdata;
    logic [AXIS_TUSER_W-1:0] tuser;
    logic [DMA_KEEP_W-1:0]   tkeep;
    logic                    tready;

    modport master (output tvalid, tlast, tdata, tuser, tkeep, input tready);
    modport slave  (input tvalid, tlast, tdata, tuser, tkeep, output tready);
endinterface

// File: rtl/wreq_dw_align_be_calc.sv
// Per-packet header math: DW length, first/last byte enables and
// input/output beat counts from the low address bits and byte length.
module wreq_be_calc
    import wreq_dw_align_pkg::*;
(
    input  logic [1:0]         i_off,
    input  logic [BLEN_W-1:0]  i_byte_len,
    output logic [DWLEN_W-1:0] o_dw_len,
    output logic [3:0]         o_first_be,
    output logic [3:0]         o_last_be,
    output logic [BEAT_W-1:0]  o_in_beats,
    output logic [BEAT_W-1:0]  o_out_beats,
    output logic               o_extra
);

    localparam logic [BLEN_W:0] C_1  = 1;
    localparam logic [BLEN_W:0] C_3  = 3;
    localparam logic [BLEN_W:0] C_31 = 31;

    logic [BLEN_W:0] w_end;
    logic [BLEN_W:0] w_dw_full;
    logic [BLEN_W:0] w_in_rnd;
    logic [BLEN_W:0] w_out_rnd;
    logic [3:0]      w_end_mask;
    logic [3:0]      w_head_be;
    logic            w_zero;
    logic            w_one_dw;
    logic            w_unused;

    assign w_end     = {1'b0, i_byte_len} + {{(BLEN_W-1){1'b0}}, i_off};
    assign w_dw_full = (w_end + C_3) >> 2;
    assign w_in_rnd  = {1'b0, i_byte_len} + C_31;
    assign w_out_rnd = w_end + C_31;
    assign w_zero    = (i_byte_len == '0);
    assign w_one_dw  = (w_dw_full == C_1);

    assign w_end_mask = (w_end[1:0] == 2'd0) ? 4'hF
                      : (4'h1 << w_end[1:0]) - 4'h1;
    assign w_head_be  = 4'hF << i_off;

    // A zero-length request still occupies one DW with no bytes enabled.
    assign o_dw_len    = w_zero ? DWLEN_W'(1) : w_dw_full[DWLEN_W-1:0];
    assign o_first_be  = w_zero   ? 4'h0
                       : w_one_dw ? (w_head_be & w_end_mask)
                       : w_head_be;
    assign o_last_be   = (w_zero | w_one_dw) ? 4'h0 : w_end_mask;
    assign o_in_beats  = w_zero ? BEAT_W'(1) : w_in_rnd[BLEN_W:5];
    assign o_out_beats = w_zero ? BEAT_W'(1) : w_out_rnd[BLEN_W:5];
    assign o_extra     = (o_out_beats > o_in_beats);

    assign w_unused = ^{w_dw_full[BLEN_W:DWLEN_W], w_in_rnd[4:0], w_out_rnd[4:0]};

endmodule

// File: rtl/wreq_dw_align.sv
// DMA write-request DW aligner: shifts address-aligned payload up by
// addr[1:0] bytes and emits a PCIe RQ-style tuser on the first beat.
module wreq_dw_align
    import wreq_dw_align_pkg::*;
(
    input  logic      dma_clk,
    input  logic      rst,
    wreq_if.slave     s_wreq,
    axis_wr_if.master m_axis_wr,
    output logic      wreq_align_err
);

    state_t r_state, w_state_nxt;

    logic [1:0]              r_off, w_off_nxt;
    logic [DWLEN_W-1:0]      r_dw_len, w_dw_nxt;
    logic                    r_extra, w_extra_nxt;
    logic [BEAT_W-1:0]       r_in_left, w_in_nxt;
    logic [BEAT_W-1:0]       r_out_left, w_out_nxt;
    logic [CARRY_W-1:0]      r_carry, w_carry_nxt;
    logic                    r_drop, w_drop_nxt;
    logic                    r_err;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic [DMA_DATA_W-1:0]   r_tdata;
    logic [AXIS_TUSER_W-1:0] r_tuser;
    logic [DMA_KEEP_W-1:0]   r_tkeep;

    logic [1:0]              w_off;
    logic [BLEN_W-1:0]       w_len;
    logic [DWLEN_W-1:0]      w_dw_len;
    logic [3:0]              w_first_be;
    logic [3:0]              w_last_be;
    logic [BEAT_W-1:0]       w_in_beats;
    logic [BEAT_W-1:0]       w_out_beats;
    logic                    w_extra;
    logic                    w_adv;
    logic                    w_acc;
    logic                    w_emit;
    logic                    w_final;
    logic                    w_err;
    logic                    w_tlast;
    logic [DMA_DATA_W-1:0]   w_cur;
    logic [CARRY_W-1:0]      w_carry;
    logic [1:0]              w_sel_off;
    logic [DMA_DATA_W-1:0]   w_tdata;
    logic [AXIS_TUSER_W-1:0] w_tuser;
    logic [DMA_KEEP_W-1:0]   w_tkeep;
    logic                    w_unused;

    assign w_off = s_wreq.head[HD_ADDR_LSB +: 2];
    assign w_len = s_wreq.head[HD_LEN_LSB +: BLEN_W];
    assign w_unused = ^{s_wreq.head[127:96], s_wreq.head[31:13]};

    wreq_be_calc u_be_calc (
        .i_off       (w_off),
        .i_byte_len  (w_len),
        .o_dw_len    (w_dw_len),
        .o_first_be  (w_first_be),
        .o_last_be   (w_last_be),
        .o_in_beats  (w_in_beats),
        .o_out_beats (w_out_beats),
        .o_extra     (w_extra)
    );

    assign w_adv        = !r_tvalid | m_axis_wr.tready;
    assign s_wreq.ready = (r_state != ST_FLUSH) & w_adv;
    assign w_acc        = s_wreq.valid & s_wreq.ready;

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_cur       = s_wreq.data;
        w_carry     = r_carry;
        w_sel_off   = r_off;
        w_tlast     = 1'b0;
        w_tuser     = '0;
        w_tkeep     = '1;
        w_err       = 1'b0;
        w_final     = 1'b0;
        w_off_nxt   = r_off;
        w_dw_nxt    = r_dw_len;
        w_extra_nxt = r_extra;
        w_in_nxt    = r_in_left;
        w_out_nxt   = r_out_left;
        w_carry_nxt = r_carry;
        w_drop_nxt  = r_drop;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_emit      = 1'b1;
                    w_carry     = '0;
                    w_sel_off   = w_off;
                    w_tlast     = (w_out_beats == BEAT_W'(1));
                    w_tkeep     = w_tlast ? last_keep(w_dw_len) : '1;
                    w_tuser[TU_ADDR_LSB +: 64]      = {s_wreq.head[HD_ADDR_LSB+2 +: 62], 2'b00};
                    w_tuser[TU_DWLEN_LSB +: DWLEN_W] = w_dw_len;
                    w_tuser[TU_FBE_LSB +: 4]        = w_first_be;
                    w_tuser[TU_LBE_LSB +: 4]        = w_last_be;
                    w_final     = (w_in_beats == BEAT_W'(1));
                    w_off_nxt   = w_off;
                    w_dw_nxt    = w_dw_len;
                    w_extra_nxt = w_extra;
                    w_in_nxt    = w_in_beats - BEAT_W'(1);
                    w_out_nxt   = w_out_beats - BEAT_W'(1);
                    w_state_nxt = !w_final ? ST_XFER
                                : w_extra  ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_XFER: begin
                if (w_acc) begin
                    w_emit      = 1'b1;
                    w_tlast     = (r_out_left == BEAT_W'(1));
                    w_tkeep     = w_tlast ? last_keep(r_dw_len) : '1;
                    w_final     = (r_in_left == BEAT_W'(1));
                    w_in_nxt    = r_in_left - BEAT_W'(1);
                    w_out_nxt   = r_out_left - BEAT_W'(1);
                    w_state_nxt = !w_final ? ST_XFER
                                : r_extra  ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (w_adv) begin
                    w_emit      = 1'b1;
                    w_cur       = '0;
                    w_tlast     = 1'b1;
                    w_tkeep     = last_keep(r_dw_len);
                    w_out_nxt   = r_out_left - BEAT_W'(1);
                    w_state_nxt = r_drop ? ST_DROP : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_acc && s_wreq.last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // The byte count decides where the packet ends; s_wreq_last is only cross-checked.
        if (w_acc && (r_state == ST_IDLE || r_state == ST_XFER)) begin
            w_err       = (s_wreq.last != w_final);
            w_carry_nxt = s_wreq.data[DMA_DATA_W-1 -: CARRY_W];
            w_drop_nxt  = !s_wreq.last;
            if (w_final && !s_wreq.last && w_state_nxt == ST_IDLE) begin
                w_state_nxt = ST_DROP;
            end
        end
    end

    assign w_tdata = dw_shift(w_cur, w_carry, w_sel_off);

    always_ff @(posedge dma_clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_off      <= '0;
            r_dw_len   <= '0;
            r_extra    <= 1'b0;
            r_in_left  <= '0;
            r_out_left <= '0;
            r_carry    <= '0;
            r_drop     <= 1'b0;
            r_err      <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
            r_tuser    <= '0;
            r_tkeep    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_off      <= w_off_nxt;
            r_dw_len   <= w_dw_nxt;
            r_extra    <= w_extra_nxt;
            r_in_left  <= w_in_nxt;
            r_out_left <= w_out_nxt;
            r_carry    <= w_carry_nxt;
            r_drop     <= w_drop_nxt;
            r_err      <= w_err;
            if (w_adv) begin
                r_tvalid <= w_emit;
                r_tlast  <= w_emit & w_tlast;
                r_tdata  <= w_emit ? w_tdata : '0;
                r_tuser  <= w_emit ? w_tuser : '0;
                r_tkeep  <= w_emit ? w_tkeep : '0;
            end
        end
    end

    assign m_axis_wr.tvalid = r_tvalid;
    assign m_axis_wr.tlast  = r_tlast;
    assign m_axis_wr.tdata  = r_tdata;
    assign m_axis_wr.tuser  = r_tuser;
    assign m_axis_wr.tkeep  = r_tkeep;
    assign wreq_align_err   = r_err;

endmodule

// File: tb/tb_wreq_dw_align.sv
// Bench for wreq_dw_align: byte-stream reference model, per-beat scoreboard
// and hand-computed header/data expectations for the directed vectors.
module tb_wreq_dw_align;
    import wreq_dw_align_pkg::*;

    typedef struct {
        logic [255:0] data;
        logic [127:0] user;
        logic [7:0]   keep;
        logic         last;
    } beat_t;

    typedef struct {
        logic [255:0] data;
        logic [127:0] user;
        logic [7:0]   keep;
        logic         last;
        int           cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic err;
    logic stall_en = 1'b0;
    logic chk_en   = 1'b1;
    int   errors   = 0;
    int   checks   = 0;
    int   err_seen = 0;
    int   cyc      = 0;
    int   e0;

    beat_t exp_q[$];
    obs_t  got_q[$];
    logic [7:0] in_bytes [0:127];

    wreq_if    u_s ();
    axis_wr_if u_m ();

    wreq_dw_align u_dut (
        .dma_clk        (clk),
        .rst            (rst),
        .s_wreq         (u_s),
        .m_axis_wr      (u_m),
        .wreq_align_err (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference: output stream = off zero bytes followed by the counted input bytes.
    task automatic model_pkt(input logic [63:0] addr, input int len);
        int off, e, dwl, nin, nout, ndw;
        logic [7:0] ob [0:191];
        beat_t bt;
        off  = int'(addr[1:0]);
        e    = off + len;
        dwl  = (len == 0) ? 1 : (e + 3) / 4;
        nin  = (len == 0) ? 1 : (len + 31) / 32;
        nout = (len == 0) ? 1 : (e + 31) / 32;
        for (int i = 0; i < 192; i++) ob[i] = 8'h00;
        for (int i = 0; i < nin * 32; i++) ob[off + i] = in_bytes[i];
        for (int k = 0; k < nout; k++) begin
            for (int b = 0; b < 32; b++) bt.data[8*b +: 8] = ob[32*k + b];
            ndw     = (k == nout - 1) ? dwl - 8 * (nout - 1) : 8;
            bt.keep = 8'((1 << ndw) - 1);
            bt.last = (k == nout - 1);
            bt.user = '0;
            if (k == 0) begin
                bt.user[95:32] = {addr[63:2], 2'b00};
                bt.user[18:8]  = 11'(dwl);
                for (int b = 0; b < 4; b++) begin
                    bt.user[4 + b] = (len > 0) && (b >= off) && (b < e);
                    bt.user[b]     = (dwl > 1) && (4 * (dwl - 1) + b < e);
                end
            end
            exp_q.push_back(bt);
        end
    endtask

    task automatic send_pkt(input logic [63:0] addr, input int len, input int nbeats,
                            input logic [3:0] lmask, input int id);
        int   t;
        logic rdy;
        for (int i = 0; i < 128; i++) in_bytes[i] = 8'(id * 16 + i);
        model_pkt(addr, len);
        for (int b = 0; b < nbeats; b++) begin
            u_s.valid = 1'b1;
            u_s.last  = lmask[b];
            u_s.head  = (b == 0) ? {32'h0, addr, 19'h0, 13'(len)} : '0;
            for (int j = 0; j < 32; j++) u_s.data[8*j +: 8] = in_bytes[32*b + j];
            t   = 0;
            rdy = 1'b0;
            while (!rdy && t < 200) begin
                @(negedge clk);
                rdy = u_s.ready;
                @(posedge clk);
                #1;
                t++;
            end
            check("send_ready", {399'b0, rdy}, 400'd1);
        end
        u_s.valid = 1'b0;
        u_s.last  = 1'b0;
        u_s.head  = '0;
        u_s.data  = '0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("drain_empty", 400'(exp_q.size()), 400'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        u_m.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_m.tready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Scoreboard: every handshake against the model, every stall for stability.
    initial begin
        logic         hold;
        logic [399:0] snap_d;
        logic [399:0] snap_c;
        obs_t         o;
        beat_t        x;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (err) err_seen++;
                if (hold && chk_en) begin
                    check("hold_data", 400'(u_m.tdata), snap_d);
                    check("hold_ctl", {262'b0, u_m.tvalid, u_m.tlast, u_m.tkeep, u_m.tuser}, snap_c);
                end
                hold   = u_m.tvalid && !u_m.tready;
                snap_d = 400'(u_m.tdata);
                snap_c = {262'b0, u_m.tvalid, u_m.tlast, u_m.tkeep, u_m.tuser};
                if (u_m.tvalid && u_m.tready) begin
                    o.data = u_m.tdata;
                    o.user = u_m.tuser;
                    o.keep = u_m.tkeep;
                    o.last = u_m.tlast;
                    o.cyc  = cyc;
                    got_q.push_back(o);
                    if (chk_en) begin
                        check("beat_expected", 400'(exp_q.size() != 0), 400'd1);
                        if (exp_q.size() != 0) begin
                            x = exp_q.pop_front();
                            check("beat_data", 400'(o.data), 400'(x.data));
                            check("beat_user", 400'(o.user), 400'(x.user));
                            check("beat_keep", 400'(o.keep), 400'(x.keep));
                            check("beat_last", 400'(o.last), 400'(x.last));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        u_s.valid = 1'b0;
        u_s.last  = 1'b0;
        u_s.head  = '0;
        u_s.data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 400'(u_m.tvalid), 400'd0);
        check("rst_tlast", 400'(u_m.tlast), 400'd0);
        check("rst_tuser", 400'(u_m.tuser), 400'd0);
        check("rst_tkeep", 400'(u_m.tkeep), 400'd0);
        check("rst_tdata", 400'(u_m.tdata), 400'd0);
        check("rst_err", 400'(err), 400'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Aligned 64 B: passthrough
        got_q.delete();
        send_pkt(64'h1000, 64, 2, 4'b0010, 1);
        drain();
        check("t1_nbeats", 400'(got_q.size()), 400'd2);
        check("t1_dwlen", 400'(got_q[0].user[18:8]), 400'd16);
        check("t1_be", 400'(got_q[0].user[7:0]), 400'hFF);
        check("t1_byte0", 400'(got_q[0].data[7:0]), 400'h10);
        check("t1_keep1", 400'(got_q[1].keep), 400'hFF);
        check("t1_last1", 400'(got_q[1].last), 400'd1);

        // Single byte at offset 3
        got_q.delete();
        send_pkt(64'h1003, 1, 1, 4'b0001, 2);
        drain();
        check("t2_nbeats", 400'(got_q.size()), 400'd1);
        check("t2_dwlen", 400'(got_q[0].user[18:8]), 400'd1);
        check("t2_be", 400'(got_q[0].user[7:0]), 400'h80);
        check("t2_addr", 400'(got_q[0].user[95:32]), 400'h1000);
        check("t2_byte3", 400'(got_q[0].data[31:24]), 400'h20);
        check("t2_keep", 400'(got_q[0].keep), 400'h01);

        // Offset 1, one full input beat spills into a flush beat
        got_q.delete();
        send_pkt(64'h1001, 32, 1, 4'b0001, 3);
        drain();
        check("t3_nbeats", 400'(got_q.size()), 400'd2);
        check("t3_dwlen", 400'(got_q[0].user[18:8]), 400'd9);
        check("t3_be", 400'(got_q[0].user[7:0]), 400'hE1);
        check("t3_flush_b0", 400'(got_q[1].data[7:0]), 400'h4F);
        check("t3_flush_keep", 400'(got_q[1].keep), 400'h01);
        check("t3_flush_last", 400'(got_q[1].last), 400'd1);

        // Offset 2, 30 B, random output stalls
        got_q.delete();
        stall_en = 1'b1;
        send_pkt(64'h1002, 30, 1, 4'b0001, 4);
        drain();
        stall_en = 1'b0;
        check("t4_nbeats", 400'(got_q.size()), 400'd1);
        check("t4_dwlen", 400'(got_q[0].user[18:8]), 400'd8);
        check("t4_be", 400'(got_q[0].user[7:0]), 400'hCF);

        // Back-to-back packets, offsets 0/1/3: output must be gap-free
        got_q.delete();
        send_pkt(64'h2000, 64, 2, 4'b0010, 5);
        send_pkt(64'h2001, 32, 1, 4'b0001, 6);
        send_pkt(64'h2003, 40, 2, 4'b0010, 7);
        drain();
        check("t5_nbeats", 400'(got_q.size()), 400'd6);
        check("t5_gapfree", 400'(got_q[5].cyc - got_q[0].cyc), 400'd5);
        check("t5_dwlen_c", 400'(got_q[4].user[18:8]), 400'd11);

        // Early s_wreq_last: error, tlast still by count
        got_q.delete();
        e0 = err_seen;
        send_pkt(64'h3000, 64, 2, 4'b0011, 8);
        drain();
        check("t6_err", 400'(err_seen - e0), 400'd1);
        check("t6_last0", 400'(got_q[0].last), 400'd0);
        check("t6_last1", 400'(got_q[1].last), 400'd1);

        // Surplus input beat is dropped
        got_q.delete();
        e0 = err_seen;
        send_pkt(64'h3004, 32, 2, 4'b0010, 9);
        drain();
        check("t7_err", 400'(err_seen - e0), 400'd1);
        check("t7_nbeats", 400'(got_q.size()), 400'd1);

        // Zero length
        got_q.delete();
        send_pkt(64'h3002, 0, 1, 4'b0001, 10);
        drain();
        check("t8_dwlen", 400'(got_q[0].user[18:8]), 400'd1);
        check("t8_be", 400'(got_q[0].user[7:0]), 400'h00);
        check("t8_keep", 400'(got_q[0].keep), 400'h01);

        // Reset mid-packet, then a clean packet
        chk_en = 1'b0;
        send_pkt(64'h4000, 64, 1, 4'b0000, 11);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_tvalid", 400'(u_m.tvalid), 400'd0);
        check("mrst_ctl", {262'b0, u_m.tlast, u_m.tkeep, u_m.tuser}, 400'd0);
        check("mrst_ready", 400'(u_s.ready), 400'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        chk_en = 1'b1;
        send_pkt(64'h4001, 32, 1, 4'b0001, 12);
        drain();
        check("t9_nbeats", 400'(got_q.size()), 400'd2);
        check("t9_be", 400'(got_q[0].user[7:0]), 400'hE1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
